// File: rtl/axis_pulse_pkg.sv
// Shared pulse generator/measurer definitions: segment states,
// cfg_data field order and bit offsets.
package axis_pulse_pkg;

  typedef enum logic [2:0] {
    S_PRE       = 3'd0,
    S_RAMP_UP   = 3'd1,
    S_FLAT      = 3'd2,
    S_RAMP_DOWN = 3'd3,
    S_POST      = 3'd4,
    S_IDLE      = 3'd7
  } state_t;

  typedef enum int {
    F_OFFSET = 0,
    F_RAMP   = 1,
    F_WIDTH  = 2,
    F_AMP    = 3,
    F_STEP   = 4,
    F_REPEAT = 5
  } cfg_field_e;

  localparam int REPEAT_W = 32;

  function automatic int cfg_lsb(
    input cfg_field_e f,
    input int pw,
    input int dw
  );
    unique case (f)
      F_OFFSET: return 0;
      F_RAMP:   return pw;
      F_WIDTH:  return 2 * pw;
      F_AMP:    return 3 * pw;
      F_STEP:   return 3 * pw + dw;
      default:  return 3 * pw + 2 * dw;
    endcase
  endfunction

  function automatic int cfg_width(
    input int pw,
    input int dw
  );
    return 3 * pw + 2 * dw + REPEAT_W;
  endfunction

endpackage

// File: rtl/axis_pulse_gen_if.sv
// AXI-Stream sample channel.
// master drives tdata/tvalid/tlast, slave drives tready.
interface axis_pulse_gen_if #(
  parameter int DW = 16
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;

  modport master (
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
    output tready
  );
endinterface

// File: rtl/axis_pulse_ramp.sv
// Saturating ramp accumulator: ld/en/up, amp, step in; value out.
// Up clamps at amp, down clamps at 0, one extra bit of headroom.
module axis_pulse_ramp #(
  parameter int DW = 16
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          en,
  input  logic          ld,
  input  logic          up,
  input  logic [DW-1:0] amp,
  input  logic [DW-1:0] step,
  output logic [DW-1:0] value
);

  localparam logic signed [DW:0] ZERO = '0;

  logic signed [DW:0] acc_q;
  logic signed [DW:0] amp_x;
  logic signed [DW:0] step_x;
  logic signed [DW:0] base;
  logic signed [DW:0] sum;
  logic signed [DW:0] res;
  logic               neg;

  assign amp_x  = {amp[DW-1], amp};
  assign step_x = {step[DW-1], step};
  assign neg    = amp[DW-1];

  always_comb begin
    base = acc_q;
    if (ld) base = up ? ZERO : amp_x;
    sum = up ? base + step_x : base - step_x;
    res = sum;
    if (up) begin
      if (!neg && sum > amp_x) res = amp_x;
      if (neg && sum < amp_x)  res = amp_x;
    end else begin
      if (!neg && sum < ZERO) res = ZERO;
      if (neg && sum > ZERO)  res = ZERO;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) acc_q <= '0;
    else if (en)  acc_q <= res;
  end

  assign value = acc_q[DW-1:0];

endmodule

// File: rtl/axis_pulse_gen.sv
// Trapezoid pulse generator on AXI-Stream: cfg_data, enable, overload in;
// m_axis samples, case_id, sts_data out. Blanking: PULSE_GEN_BLANK_EN.
module axis_pulse_gen
  import axis_pulse_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter int PULSE_WIDTH      = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [PULSE_WIDTH*3+AXIS_TDATA_WIDTH*2+32-1:0] cfg_data,
  input  logic        enable,
  input  logic        overload,
  axis_pulse_gen_if.master m_axis,
  output logic [2:0]  case_id,
  output logic [31:0] sts_data
);

  localparam int DW = AXIS_TDATA_WIDTH;
  localparam int PW = PULSE_WIDTH;
  localparam int L_OFF = cfg_lsb(F_OFFSET, PW, DW);
  localparam int L_RMP = cfg_lsb(F_RAMP, PW, DW);
  localparam int L_WID = cfg_lsb(F_WIDTH, PW, DW);
  localparam int L_AMP = cfg_lsb(F_AMP, PW, DW);
  localparam int L_STP = cfg_lsb(F_STEP, PW, DW);
  localparam int L_REP = cfg_lsb(F_REPEAT, PW, DW);
  localparam logic [PW-1:0] ONE = 1;

  logic [PW-1:0] off_len, ramp_len, flat_len;
  logic [DW-1:0] cfg_amp, cfg_step;
  logic [31:0]   rep;

  assign off_len  = cfg_data[L_OFF +: PW];
  assign ramp_len = cfg_data[L_RMP +: PW];
  assign flat_len = cfg_data[L_WID +: PW];
  assign cfg_amp  = cfg_data[L_AMP +: DW];
  assign cfg_step = cfg_data[L_STP +: DW];
  assign rep      = cfg_data[L_REP +: 32];

  state_t        state_q, state_d, after;
  logic [PW-1:0] cnt_q, cnt_d, seg_len;
  logic [31:0]   sts_q, sts_d;
  logic [DW-1:0] amp_q, step_q, amp_nx, step_nx;
  logic [DW-1:0] ramp_val;
  logic [4:0]    nz;
  logic          hs, last_beat, start, blank;
  logic          r_en, r_ld, r_up;

  function automatic state_t first_nz(
    input logic [4:0] m
  );
    priority case (1'b1)
      m[0]:    return S_PRE;
      m[1]:    return S_RAMP_UP;
      m[2]:    return S_FLAT;
      m[3]:    return S_RAMP_DOWN;
      m[4]:    return S_POST;
      default: return S_IDLE;
    endcase
  endfunction

  // bit i set when segment state i has nonzero length
  assign nz = {|off_len, |ramp_len, |flat_len,
               |ramp_len, |off_len};

  assign after = first_nz(nz & (5'b11110 << state_q));

  always_comb begin
    unique case (state_q)
      S_PRE, S_POST:          seg_len = off_len;
      S_RAMP_UP, S_RAMP_DOWN: seg_len = ramp_len;
      S_FLAT:                 seg_len = flat_len;
      default:                seg_len = '0;
    endcase
  end

  assign m_axis.tvalid = state_q != S_IDLE;
  assign hs        = m_axis.tvalid & m_axis.tready;
  assign last_beat = cnt_q == seg_len - ONE;
  assign m_axis.tlast = m_axis.tvalid & last_beat
                      & (after == S_IDLE);

`ifdef PULSE_GEN_BLANK_EN
  assign blank = overload;
`else
  logic unused_overload;
  assign unused_overload = overload;
  assign blank = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sts_d   = sts_q;
    start   = 1'b0;
    if (state_q == S_IDLE) begin
      if (enable && |nz) begin
        start   = 1'b1;
        state_d = first_nz(nz);
        cnt_d   = '0;
        sts_d   = '0;
      end
    end else if (hs) begin
      if (!last_beat) begin
        cnt_d = cnt_q + ONE;
      end else begin
        cnt_d = '0;
        if (after != S_IDLE) begin
          state_d = after;
        end else begin
          sts_d = sts_q + 32'd1;
          if (!enable || (rep != 0 && sts_d == rep)) begin
            state_d = S_IDLE;
          end else begin
            start   = 1'b1;
            state_d = first_nz(nz);
          end
        end
      end
    end
  end

  // the ramp must see amplitude/step of a pulse starting this cycle
  assign amp_nx  = start ? (blank ? '0 : cfg_amp) : amp_q;
  assign step_nx = start ? (blank ? '0 : cfg_step) : step_q;

  assign r_up = state_d == S_RAMP_UP;
  assign r_ld = state_d != state_q;
  assign r_en = (r_up || state_d == S_RAMP_DOWN) && (r_ld || hs);

  axis_pulse_ramp #(.DW(DW)) u_ramp (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (r_en),
    .ld      (r_ld),
    .up      (r_up),
    .amp     (amp_nx),
    .step    (step_nx),
    .value   (ramp_val)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sts_q   <= '0;
      amp_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sts_q   <= sts_d;
      amp_q   <= amp_nx;
      step_q  <= step_nx;
    end
  end

  always_comb begin
    unique case (state_q)
      S_RAMP_UP, S_RAMP_DOWN: m_axis.tdata = ramp_val;
      S_FLAT:                 m_axis.tdata = amp_q;
      default:                m_axis.tdata = '0;
    endcase
  end

  assign case_id  = state_q;
  assign sts_data = sts_q;

endmodule

// File: tb/tb_axis_pulse_gen.sv
// Directed bench for axis_pulse_gen: basic, saturation, backpressure,
// zero segments, continuous/repeat, blanking, reset mid-pulse.
module tb_axis_pulse_gen;

  localparam int DW = 16;
  localparam int PW = 16;
  localparam int CW = 3 * PW + 2 * DW + 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [CW-1:0] cfg_data = '0;
  logic          enable = 1'b0;
  logic          overload = 1'b0;
  logic [2:0]    case_id;
  logic [31:0]   sts_data;

  axis_pulse_gen_if #(.DW(DW)) axis ();

  axis_pulse_gen #(
    .AXIS_TDATA_WIDTH (DW),
    .PULSE_WIDTH      (PW)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .cfg_data (cfg_data),
    .enable   (enable),
    .overload (overload),
    .m_axis   (axis),
    .case_id  (case_id),
    .sts_data (sts_data)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_fail = 0;
  int q_d[$];
  bit q_l[$];
  int bubbles;
  int e[$];
  int basic[$];

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_cfg(input int off, input int rmp, input int wid,
                         input int amp, input int stp, input int rp);
    cfg_data = {32'(rp), 16'(stp), 16'(amp),
                16'(wid), 16'(rmp), 16'(off)};
  endtask

  task automatic start_pulse(input string tag);
    enable = 1'b1;
    chk({tag, "_idle_before"}, longint'(axis.tvalid), 0);
    tick();
    chk({tag, "_first_valid"}, longint'(axis.tvalid), 1);
  endtask

  task automatic collect(input int k, input bit tog, input bit drop);
    int seen;
    int cyc;
    int hd;
    bit hl;
    bit stalled;
    q_d.delete();
    q_l.delete();
    bubbles = 0;
    seen = 0;
    cyc = 0;
    stalled = 0;
    hd = 0;
    hl = 0;
    while (seen < k && cyc < 400) begin
      axis.tready = tog ? ~cyc[0] : 1'b1;
      if (stalled) begin
        chk("stall_data", int'($signed(axis.tdata)), hd);
        chk("stall_last", longint'(axis.tlast), longint'(hl));
      end
      stalled = 0;
      if (axis.tvalid) begin
        if (axis.tready) begin
          q_d.push_back(int'($signed(axis.tdata)));
          q_l.push_back(axis.tlast);
          if (axis.tlast) begin
            seen++;
            if (seen == k && drop) enable = 1'b0;
          end
        end else begin
          stalled = 1;
          hd = int'($signed(axis.tdata));
          hl = axis.tlast;
        end
      end else if (q_d.size() > 0) begin
        bubbles++;
      end
      tick();
      cyc++;
    end
    axis.tready = 1'b1;
    if (seen < k) chk("collect_timeout", seen, k);
  endtask

  task automatic check_seq(input string tag, input int ex[$],
                           input int np);
    int nl;
    nl = 0;
    chk({tag, "_len"}, q_d.size(), ex.size());
    for (int i = 0; i < ex.size() && i < q_d.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), q_d[i], ex[i]);
    foreach (q_l[i]) nl += int'(q_l[i]);
    chk({tag, "_ntlast"}, nl, np);
    if (q_l.size() > 0)
      chk({tag, "_tlast_end"}, longint'(q_l[q_l.size()-1]), 1);
  endtask

  initial begin
    bit seen_v;
    axis.tready = 1'b1;
    basic = '{0, 0, 40, 80, 100, 100, 100, 60, 20, 0, 0};

    // reset state
    repeat (3) tick();
    chk("rst_case", case_id, 7);
    chk("rst_valid", longint'(axis.tvalid), 0);
    chk("rst_last", longint'(axis.tlast), 0);
    chk("rst_data", axis.tdata, 0);
    chk("rst_sts", sts_data, 0);
    aresetn = 1'b1;
    tick();

    // basic pulse
    set_cfg(2, 2, 3, 100, 40, 1);
    start_pulse("basic");
    chk("basic_case0", case_id, 0);
    collect(1, 0, 1);
    check_seq("basic", basic, 1);
    chk("basic_sts", sts_data, 1);
    chk("basic_idle", case_id, 7);
    chk("basic_vlow", longint'(axis.tvalid), 0);

    // negative amplitude saturation
    set_cfg(1, 3, 1, -100, -60, 0);
    start_pulse("sat");
    collect(1, 0, 1);
    e = '{0, -60, -100, -100, -100, -40, 0, 0, 0};
    check_seq("sat", e, 1);
    chk("sat_sts", sts_data, 1);

    // backpressure
    set_cfg(2, 2, 3, 100, 40, 1);
    start_pulse("bp");
    collect(1, 1, 1);
    check_seq("bp", basic, 1);
    chk("bp_sts", sts_data, 1);

    // zero-length segments skipped
    set_cfg(0, 0, 4, 77, 10, 0);
    start_pulse("zero");
    chk("zero_case", case_id, 2);
    collect(1, 0, 1);
    e = '{77, 77, 77, 77};
    check_seq("zero", e, 1);

    // all-zero lengths: never valid
    set_cfg(0, 0, 0, 77, 10, 0);
    enable = 1'b1;
    seen_v = 0;
    repeat (20) begin
      tick();
      if (axis.tvalid) seen_v = 1;
    end
    enable = 1'b0;
    chk("allzero_valid", longint'(seen_v), 0);
    chk("allzero_sts", sts_data, 1);

    // continuous: two back-to-back pulses, then stop mid-pulse
    set_cfg(2, 2, 3, 100, 40, 0);
    start_pulse("cont");
    collect(2, 0, 0);
    e = {basic, basic};
    check_seq("cont", e, 2);
    chk("cont_bubbles", bubbles, 0);
    chk("cont_sts2", sts_data, 2);
    repeat (3) tick();
    // new amplitude must not affect the pulse in flight
    set_cfg(2, 2, 3, 120, 40, 0);
    enable = 1'b0;
    collect(1, 0, 0);
    e = '{80, 100, 100, 100, 60, 20, 0, 0};
    check_seq("cont_tail", e, 1);
    chk("cont_sts3", sts_data, 3);
    chk("cont_idle", longint'(axis.tvalid), 0);

    // repeat count with enable held
    set_cfg(0, 0, 2, 5, 1, 2);
    start_pulse("rep");
    collect(2, 0, 0);
    e = '{5, 5, 5, 5};
    check_seq("rep", e, 2);
    chk("rep_idle", longint'(axis.tvalid), 0);
    chk("rep_sts", sts_data, 2);
    tick();
    chk("rep_restart", longint'(axis.tvalid), 1);
    chk("rep_sts_clr", sts_data, 0);
    enable = 1'b0;
    collect(1, 0, 0);
    e = '{5, 5};
    check_seq("rep_tail", e, 1);
    chk("rep_sts_end", sts_data, 1);

    // blanking
    set_cfg(2, 2, 3, 100, 40, 1);
    overload = 1'b1;
    start_pulse("blank");
    overload = 1'b0;
    collect(1, 0, 1);
`ifdef PULSE_GEN_BLANK_EN
    e = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
    e = basic;
`endif
    check_seq("blank", e, 1);
    chk("blank_sts", sts_data, 1);

    // reset mid-pulse
    set_cfg(2, 2, 3, 100, 40, 0);
    start_pulse("mrst");
    repeat (4) tick();
    aresetn = 1'b0;
    tick();
    chk("mrst_valid", longint'(axis.tvalid), 0);
    chk("mrst_last", longint'(axis.tlast), 0);
    chk("mrst_case", case_id, 7);
    chk("mrst_data", axis.tdata, 0);
    chk("mrst_sts", sts_data, 0);
    enable = 1'b0;
    aresetn = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
